clock_time_counter: RTL and testbench



---
 rtl/clock_time_counter.sv | 140 ++++++++++++++
 tb/tb_clock_time_counter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_counter.sv
// rtl/clock_time_counter.sv - BCD hh:mm:ss time-of-day counter with button-driven set mode
module clock_time_counter #(
  parameter int HOURS       = 24,
  parameter int TICK_ACTIVE = 1
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] sec_u,
  output logic [3:0] sec_t,
  output logic [3:0] min_u,
  output logic [3:0] min_t,
  output logic [3:0] hr_u,
  output logic [3:0] hr_t,
  output logic       set_hr,
  output logic       set_min,
  output logic       day_pulse
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  // Last legal hour split into BCD digits (23 or 11)
  localparam logic [3:0] HR_LIM_T = 4'((HOURS - 1) / 10);
  localparam logic [3:0] HR_LIM_U = 4'((HOURS - 1) % 10);
  localparam logic       TICK_LVL = (TICK_ACTIVE != 0);

  state_t     state_q, state_d;
  logic       mode_prev, inc_prev;
  logic       mode_press, inc_press, tick;
  logic       sec_wrap, min_wrap, hr_wrap;
  logic [3:0] sec_inc_u, sec_inc_t, min_inc_u, min_inc_t, hr_inc_u, hr_inc_t;
  logic [3:0] sec_u_d, sec_t_d, min_u_d, min_t_d, hr_u_d, hr_t_d;
  logic       set_hr_d, set_min_d, day_pulse_d;

  // Rising-edge press detection; a mode press suppresses a coincident inc press
  assign mode_press = btn_mode & ~mode_prev;
  assign inc_press  = btn_inc & ~inc_prev & ~mode_press;
  assign tick       = (tick_in == TICK_LVL);

  assign sec_wrap = (sec_t == 4'd5) && (sec_u == 4'd9);
  assign min_wrap = (min_t == 4'd5) && (min_u == 4'd9);
  assign hr_wrap  = (hr_t == HR_LIM_T) && (hr_u == HR_LIM_U);

  // Per-digit BCD increments; each field wraps to 00 at its limit
  assign sec_inc_u = (sec_u == 4'd9) ? 4'd0 : sec_u + 4'd1;
  assign sec_inc_t = (sec_u != 4'd9) ? sec_t : (sec_t == 4'd5) ? 4'd0 : sec_t + 4'd1;
  assign min_inc_u = (min_u == 4'd9) ? 4'd0 : min_u + 4'd1;
  assign min_inc_t = (min_u != 4'd9) ? min_t : (min_t == 4'd5) ? 4'd0 : min_t + 4'd1;
  assign hr_inc_u  = (hr_wrap || hr_u == 4'd9) ? 4'd0 : hr_u + 4'd1;
  assign hr_inc_t  = hr_wrap ? 4'd0 : (hr_u == 4'd9) ? hr_t + 4'd1 : hr_t;

  // Next state and next time digits for the current mode
  always_comb begin
    state_d     = state_q;
    sec_u_d     = sec_u;
    sec_t_d     = sec_t;
    min_u_d     = min_u;
    min_t_d     = min_t;
    hr_u_d      = hr_u;
    hr_t_d      = hr_t;
    day_pulse_d = 1'b0;
    case (state_q)
      RUN: begin
        if (tick) begin
          sec_u_d = sec_inc_u;
          sec_t_d = sec_inc_t;
          if (sec_wrap) begin
            min_u_d = min_inc_u;
            min_t_d = min_inc_t;
            if (min_wrap) begin
              hr_u_d      = hr_inc_u;
              hr_t_d      = hr_inc_t;
              day_pulse_d = hr_wrap;
            end
          end
        end
        if (mode_press) state_d = SET_HOUR;
      end
      SET_HOUR: begin
        if (mode_press) begin
          state_d = SET_MIN;
        end else if (inc_press) begin
          hr_u_d = hr_inc_u;
          hr_t_d = hr_inc_t;
        end
      end
      SET_MIN: begin
        if (mode_press) begin
          state_d = RUN;
          sec_u_d = 4'd0;
          sec_t_d = 4'd0;
        end else if (inc_press) begin
          min_u_d = min_inc_u;
          min_t_d = min_inc_t;
        end
      end
      default: state_d = RUN;
    endcase
    set_hr_d  = (state_d == SET_HOUR);
    set_min_d = (state_d == SET_MIN);
  end

  // State, time digits, flags and button history registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q   <= RUN;
      mode_prev <= 1'b1;
      inc_prev  <= 1'b1;
      sec_u     <= 4'd0;
      sec_t     <= 4'd0;
      min_u     <= 4'd0;
      min_t     <= 4'd0;
      hr_u      <= 4'd0;
      hr_t      <= 4'd0;
      set_hr    <= 1'b0;
      set_min   <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_prev <= btn_mode;
      inc_prev  <= btn_inc;
      sec_u     <= sec_u_d;
      sec_t     <= sec_t_d;
      min_u     <= min_u_d;
      min_t     <= min_t_d;
      hr_u      <= hr_u_d;
      hr_t      <= hr_t_d;
      set_hr    <= set_hr_d;
      set_min   <= set_min_d;
      day_pulse <= day_pulse_d;
    end
  end

endmodule

// File: tb/tb_clock_time_counter.sv
// tb/tb_clock_time_counter.sv - self-checking bench for clock_time_counter (24h and 12h builds)
module tb_clock_time_counter;

  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic tick_in = 1'b0;
  logic btn_mode = 1'b0;
  logic btn_inc = 1'b0;

  logic [3:0] a_su, a_st, a_mu, a_mt, a_hu, a_ht;
  logic       a_shr, a_smin, a_dp;
  logic [3:0] b_su, b_st, b_mu, b_mt, b_hu, b_ht;
  logic       b_shr, b_smin, b_dp;

  always #5 clk_in = ~clk_in;

  clock_time_counter #(.HOURS(24), .TICK_ACTIVE(1)) dut24 (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_u(a_su), .sec_t(a_st), .min_u(a_mu), .min_t(a_mt), .hr_u(a_hu), .hr_t(a_ht),
    .set_hr(a_shr), .set_min(a_smin), .day_pulse(a_dp)
  );

  clock_time_counter #(.HOURS(12), .TICK_ACTIVE(1)) dut12 (
    .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_u(b_su), .sec_t(b_st), .min_u(b_mu), .min_t(b_mt), .hr_u(b_hu), .hr_t(b_ht),
    .set_hr(b_shr), .set_min(b_smin), .day_pulse(b_dp)
  );

  logic [26:0] obs [2];
  assign obs[0] = {a_ht, a_hu, a_mt, a_mu, a_st, a_su, a_shr, a_smin, a_dp};
  assign obs[1] = {b_ht, b_hu, b_mt, b_mu, b_st, b_su, b_shr, b_smin, b_dp};

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  // Reference model: time kept as seconds-of-day, mode as 0=run 1=set hour 2=set minute
  int m_t [2];
  int m_st [2];
  bit m_dp [2];
  bit m_pm = 1'b1;
  bit m_pi = 1'b1;
  bit mp, ip;
  int day, hh, mm;

  function automatic int hrs(input int i);
    return (i == 0) ? 24 : 12;
  endfunction

  function automatic logic [26:0] exp_obs(input int t, input int st, input bit dp);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            (st == 1), (st == 2), dp};
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_t[i] = 0; m_st[i] = 0; m_dp[i] = 1'b0;
    end
  end

  always @(posedge clk_in) begin
    mp = btn_mode && !m_pm;
    ip = btn_inc && !m_pi && !mp;
    for (int i = 0; i < 2; i++) begin
      day = hrs(i) * 3600;
      m_dp[i] = 1'b0;
      if (rst) begin
        m_t[i] = 0;
        m_st[i] = 0;
      end else begin
        case (m_st[i])
          0: begin
            if (tick_in) begin
              if (m_t[i] == day - 1) m_dp[i] = 1'b1;
              m_t[i] = (m_t[i] + 1) % day;
            end
            if (mp) m_st[i] = 1;
          end
          1: begin
            if (mp) m_st[i] = 2;
            else if (ip) begin
              hh = m_t[i] / 3600;
              m_t[i] = ((hh + 1) % hrs(i)) * 3600 + m_t[i] % 3600;
            end
          end
          default: begin
            if (mp) begin
              m_st[i] = 0;
              m_t[i] = m_t[i] - m_t[i] % 60;
            end else if (ip) begin
              mm = (m_t[i] / 60) % 60;
              m_t[i] = m_t[i] - mm * 60 + ((mm + 1) % 60) * 60;
            end
          end
        endcase
      end
    end
    m_pm = rst ? 1'b1 : btn_mode;
    m_pi = rst ? 1'b1 : btn_inc;
  end

  // Every-cycle comparison of both builds against the model
  always @(negedge clk_in) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs[i] !== exp_obs(m_t[i], m_st[i], m_dp[i])) begin
          miscompares++;
          $display("FAIL cycle_cmp dut%0d at %0t: got=%h want=%h", hrs(i), $time, obs[i],
                   exp_obs(m_t[i], m_st[i], m_dp[i]));
        end
      end
    end
  end

  task automatic check_lit(input string name, input int i, input int h, input int m,
                           input int s, input int st, input bit dp);
    logic [26:0] want;
    want = exp_obs(h * 3600 + m * 60 + s, st, dp);
    vectors++;
    if (obs[i] !== want) begin
      miscompares++;
      $display("FAIL %s dut%0d: got=%h want=%h", name, hrs(i), obs[i], want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; cyc(1); btn_mode = 1'b0; cyc(1);
  endtask

  task automatic press_inc(input int n, input bit tk);
    repeat (n) begin
      btn_inc = 1'b1; tick_in = tk; cyc(1);
      btn_inc = 1'b0; cyc(1);
      tick_in = 1'b0;
    end
  endtask

  task automatic ticks(input int n, input int gap);
    repeat (n) begin
      tick_in = 1'b1; cyc(1); tick_in = 1'b0; cyc(gap - 1);
    end
  endtask

  initial begin
    cyc(1);
    check_en = 1'b1;
    cyc(1);
    check_lit("reset_state", 0, 0, 0, 0, 0, 0);
    check_lit("reset_state", 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    cyc(1);

    ticks(61, 4);
    check_lit("61_ticks", 0, 0, 1, 1, 0, 0);

    press_mode();
    press_inc(23, 1'b0);
    press_mode();
    press_inc(58, 1'b0);
    press_mode();
    check_lit("set_23_59", 0, 23, 59, 0, 0, 0);
    check_lit("set_11_59", 1, 11, 59, 0, 0, 0);
    ticks(59, 2);
    check_lit("pre_wrap", 0, 23, 59, 59, 0, 0);
    tick_in = 1'b1; cyc(1);
    check_lit("day_wrap24", 0, 0, 0, 0, 0, 1);
    check_lit("day_wrap12", 1, 0, 0, 0, 0, 1);
    tick_in = 1'b0; cyc(1);
    check_lit("day_pulse_one_cycle", 0, 0, 0, 0, 0, 0);

    ticks(7, 3);
    press_mode();
    press_inc(25, 1'b1);
    check_lit("hour_wrap25", 0, 1, 0, 7, 1, 0);
    check_lit("hour_wrap25_12", 1, 1, 0, 7, 1, 0);

    press_mode();
    press_inc(59, 1'b1);
    check_lit("min_59", 0, 1, 59, 7, 2, 0);
    press_inc(1, 1'b0);
    check_lit("min_wrap_no_carry", 0, 1, 0, 7, 2, 0);
    press_mode();
    check_lit("exit_clears_sec", 0, 1, 0, 0, 0, 0);

    btn_mode = 1'b1; btn_inc = 1'b1; cyc(1);
    check_lit("mode_beats_inc", 0, 1, 0, 0, 1, 0);
    btn_mode = 1'b0; cyc(1);
    btn_inc = 1'b0; cyc(1);
    btn_inc = 1'b1; cyc(100);
    btn_inc = 1'b0; cyc(1);
    check_lit("held_inc_once", 0, 2, 0, 0, 1, 0);
    press_mode();
    press_mode();

    rst = 1'b1; btn_mode = 1'b1; cyc(3);
    rst = 1'b0; cyc(5);
    check_lit("mode_held_thru_reset", 0, 0, 0, 0, 0, 0);
    btn_mode = 1'b0; cyc(1);
    press_mode();
    press_inc(12, 1'b0);
    press_mode();
    press_inc(34, 1'b0);
    press_mode();
    ticks(56, 2);
    press_mode();
    press_mode();
    check_lit("at_12_34_56", 0, 12, 34, 56, 2, 0);
    check_lit("at_00_34_56", 1, 0, 34, 56, 2, 0);
    rst = 1'b1; cyc(1);
    check_lit("reset_mid_op", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int k = 0; k < 4000; k++) begin
      tick_in = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 19) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 3) == 0) btn_inc = ~btn_inc;
      rst = ($urandom_range(0, 599) == 0);
      cyc(1);
    end
    rst = 1'b0; tick_in = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    cyc(2);

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
